// File: rtl/nibble_serial_adder.sv
// Multi-cycle wide adder: one 4-bit slice per clock, LSB slice first, with a
// registered inter-slice carry. Results are published atomically on completion.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for start; last sum/cout/ovf held
// ADD   | one slice per edge; publishes result on slice NIBBLES-1
module nibble_serial_adder #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic {IDLE = 1'b0, ADD = 1'b1} state_t;

  state_t         state, state_nx;
  logic [W-1:0]   a_sh, b_sh, res_sh, res_nx;
  logic [W+3:0]   res_cat;
  logic [4:0]     slice;
  logic [CW-1:0]  cnt;
  logic           carry_reg, a_msb, b_msb, last;

  // Full 5-bit slice add so the carry is never lost to truncation.
  assign slice   = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_reg};
  assign res_cat = {slice[3:0], res_sh};
  assign res_nx  = res_cat[W+3:4];
  assign last    = (cnt == CW'(NIBBLES - 1));
  assign busy    = (state == ADD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = ADD;
      ADD:     if (last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      res_sh    <= '0;
      cnt       <= '0;
      carry_reg <= 1'b0;
      a_msb     <= 1'b0;
      b_msb     <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh      <= a;
            b_sh      <= b;
            carry_reg <= cin;
            a_msb     <= a[W-1];
            b_msb     <= b[W-1];
            res_sh    <= '0;
            cnt       <= '0;
          end
        end
        ADD: begin
          a_sh      <= a_sh >> 4;
          b_sh      <= b_sh >> 4;
          res_sh    <= res_nx;
          carry_reg <= slice[4];
          cnt       <= cnt + 1'b1;
          if (last) begin
            sum  <= res_nx;
            cout <= slice[4];
            ovf  <= (a_msb == b_msb) && (res_nx[W-1] != a_msb);
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
